// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pattern transmitter and its detector.
package serial_pkg;

  localparam int unsigned NBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB out, zero fill; load wins over shift.
module piso_shreg #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [NBITS-1:0] i_data,
  output logic             o_msb
);

  logic [NBITS-1:0] r_q;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[NBITS-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[NBITS-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial MSB-first pattern transmitter with repeat and a golden equal-pair flag
// for the two-consecutive-equal-bits detector.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEFAULT
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NBITS-1:0]         pattern,
  input  logic                     repeat_en,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NBITS)-1:0] bit_idx,
  output logic                     expect_pair
);

  localparam int unsigned CW = $clog2(NBITS);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [NBITS-1:0] r_pat_hold;
  logic [NBITS-1:0] w_load_data;
  logic             w_load;
  logic             w_shift;
  logic             w_hold_cap;
  logic             w_msb;
  logic             r_last_bit;
  logic             r_have_last;

  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_bit_idx;
  logic             r_expect_pair;

  piso_shreg #(.NBITS(NBITS)) u_shreg (
    .clk_2   (clk_2),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and shift-register control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_hold_cap  = 1'b0;
    w_load_data = pattern;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_hold_cap  = 1'b1;
          w_cnt_nxt   = CW'(NBITS - 1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      DONE: begin
        if (repeat_en) begin
          w_load      = 1'b1;
          w_load_data = r_pat_hold;
          w_cnt_nxt   = CW'(NBITS - 1);
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_pat_hold <= '0;
    end else if (w_hold_cap) begin
      r_pat_hold <= pattern;
    end
  end

  // Pair history; the DONE gap breaks it so repeated bursts start clean
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_last_bit  <= 1'b0;
      r_have_last <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_last_bit  <= w_msb;
      r_have_last <= 1'b1;
    end else if (r_state == DONE) begin
      r_have_last <= 1'b0;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_out_bit     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bit_idx     <= '0;
      r_expect_pair <= 1'b0;
    end else begin
      r_out_bit     <= (r_state == SHIFT) & w_msb;
      r_out_valid   <= (r_state == SHIFT);
      r_busy        <= (r_state == SHIFT) | (r_state == DONE);
      r_done        <= (r_state == DONE);
      r_bit_idx     <= (r_state == SHIFT) ? r_cnt : '0;
      r_expect_pair <= (r_state == SHIFT) & r_have_last & (w_msb == r_last_bit);
    end
  end

  assign out_bit     = r_out_bit;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bit_idx     = r_bit_idx;
  assign expect_pair = r_expect_pair;

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter for the FSM lab designs. It latches an NBITS-wide pattern from the switches and shifts it out MSB-first, one bit per clk_2 cycle, on a single serial line. It is the driving end of the two-consecutive-equal-bits sequence detector, replacing manual toggling of the serial input. A companion flag, expect_pair, is a cycle-exact golden model of what the detector must report, so the pair can self-check on the board LEDs.

## Interface
- NBITS, default 8: pattern width and burst length in bits; legal range 2..32.
- clk_2  input  1  system clock, slow board clock.
- reset  input  1  reset, synchronous, active-high; clock clk_2.
- start  input  1  request to transmit; level-sampled, acted on only in IDLE.
- pattern  input  NBITS  word to transmit; sampled only on the accepting cycle.
- repeat_en  input  1  when high in DONE, the same latched word is retransmitted.
- out_bit  output  1  serial data; 0 whenever out_valid is 0.
- out_valid  output  1  out_bit carries a pattern bit this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse after the last bit of a burst.
- bit_idx  output  $clog2(NBITS)  index of the bit on out_bit; 0 outside SHIFT.
- expect_pair  output  1  high when out_valid is 1 and out_bit equals the previous bit of the same burst.

## Operation
- States: IDLE, SHIFT, DONE. State encoding is registered.
- IDLE:
  - out_valid, busy, done and expect_pair are 0.
  - If start is 1, latch pattern into shreg, set cnt = NBITS-1 and go to SHIFT.
- SHIFT:
  - out_bit = shreg[NBITS-1], out_valid = 1, bit_idx = cnt.
  - Each cycle: shift shreg left by 1 with 0 fill, store the emitted bit in last_bit, set have_last = 1, decrement cnt.
  - When cnt == 0, the current bit is the last one; go to DONE.
- DONE:
  - done = 1, out_valid = 0, out_bit = 0, have_last cleared.
  - If repeat_en = 1, reload shreg from the held copy in pat_hold, set cnt = NBITS-1 and go to SHIFT.
  - Otherwise go to IDLE.
- pat_hold captures pattern together with shreg on acceptance. The pattern input is ignored at all other times, including when its value changes mid-burst.
- start while busy is ignored; no queuing. start held high continuously gives back-to-back bursts with one DONE cycle plus one IDLE cycle between them.
- expect_pair = out_valid & have_last & (out_bit == last_bit).
  - The first bit of every burst never asserts it, including repeated bursts, because the DONE gap breaks the history.
- Reset, including mid-burst: state = IDLE, and shreg, pat_hold, cnt, last_bit and have_last are all cleared. All outputs are 0 on the cycle after reset is sampled. Reset has priority over start and repeat_en.

## Timing
- Accept latency: start sampled high in IDLE at edge k puts bit NBITS-1 on out_bit after edge k+1.
- Burst: exactly NBITS consecutive out_valid cycles, followed by exactly one done cycle.
- Repeat period: NBITS+1 cycles (one DONE cycle, no IDLE cycle). Non-repeat restart period: NBITS+2 cycles minimum.
- All outputs are registered-state decodes, with no combinational path from the inputs.
- expect_pair is aligned with out_bit. The downstream detector, being registered, flags the same pair one cycle later; checkers compare with a 1-cycle lag.

## Structure
- A shared package serial_pkg holds:
  - the tx_state_t enum {IDLE, SHIFT, DONE};
  - the NBITS_DEFAULT = 8 constant.
- The detector FSM imports the same package for its width constant.
- One natural sub-module, piso_shreg: a parallel-in serial-out shift register with load and shift enables, NBITS wide, MSB out.
- The FSM, cnt, pat_hold and the pair tracker stay in serial_pattern_tx.

## Test plan
- Reset, then start=1 with pattern=8'b1100_1010:
  - out_bit over 8 cycles is 1,1,0,0,1,0,1,0 with bit_idx 7..0;
  - expect_pair is high on the 2nd and 4th bits only;
  - done pulses on cycle 9, then busy drops.
- pattern=8'hFF with repeat_en=1 for 3 bursts: expect_pair is 0,1,1,1,1,1,1,1 per burst; done every 9 cycles; out_valid is low exactly on the DONE cycles.
- pattern=8'h55: expect_pair is never asserted; out_bit alternates 0,1.
- start pulsed at bit_idx 3 of a burst, and pattern changed to 8'h00 mid-burst: the burst completes unchanged with the original word, and no second burst starts.
- Reset asserted at bit_idx 4 of an 8'hF0 burst: the next cycle has out_valid=0, busy=0, bit_idx=0. A new start then transmits fresh with no stale expect_pair on its first bit.
- NBITS=2 instance, pattern=2'b11, start held high: the sequence is 1,1 (expect_pair on the 2nd bit), then DONE, IDLE, then the burst repeats with period 4.
